// File: rtl/dp_stream_splitter.sv
// dp_stream_splitter: splits a header+data word stream into dot_product A/B lanes.
// Optional stall counter output enabled by defining DP_SPLIT_PERF_EN.
module dp_stream_splitter #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [LEN_W-1:0] len,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic             busy,
    output logic             err_zero
`ifdef DP_SPLIT_PERF_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);
    typedef enum logic [1:0] {IDLE, RUN_A, RUN_B, RUN_I} state_t;
    state_t state;
    logic [LEN_W-1:0] cnt_a, cnt_b;
    logic steer, up;
    logic [LEN_W-1:0] hdr_n;
    logic hdr_mode, tgt_b, tgt_free, acc, load_a, load_b, last_a, last_b;
    always_comb begin
        hdr_n    = in_data[LEN_W-1:0];
        hdr_mode = in_data[LEN_W];
        tgt_b    = state == RUN_B || (state == RUN_I && steer);
        tgt_free = tgt_b ? (!b_valid || b_ready) : (!a_valid || a_ready);
        in_ready = up && (state == IDLE || tgt_free);
        acc      = in_valid && in_ready;
        load_a   = acc && (state == RUN_A || (state == RUN_I && !steer));
        load_b   = acc && tgt_b;
        last_a   = cnt_a == len - 1'b1;
        last_b   = cnt_b == len - 1'b1;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            up       <= 1'b0;
            len      <= '0;
            cnt_a    <= '0;
            cnt_b    <= '0;
            steer    <= 1'b0;
            a_data   <= '0;
            a_valid  <= 1'b0;
            b_data   <= '0;
            b_valid  <= 1'b0;
            busy     <= 1'b0;
            err_zero <= 1'b0;
        end else begin
            up       <= 1'b1;
            busy     <= state != IDLE;
            err_zero <= acc && state == IDLE && hdr_n == '0;
            if (load_a) begin
                a_data  <= in_data;
                a_valid <= 1'b1;
            end else if (a_ready) a_valid <= 1'b0;
            if (load_b) begin
                b_data  <= in_data;
                b_valid <= 1'b1;
            end else if (b_ready) b_valid <= 1'b0;
            case (state)
                IDLE: if (acc && hdr_n != '0) begin
                    len   <= hdr_n;
                    cnt_a <= '0;
                    cnt_b <= '0;
                    steer <= 1'b0;
                    state <= hdr_mode ? RUN_I : RUN_A;
                end
                RUN_A: if (acc) begin
                    cnt_a <= cnt_a + 1'b1;
                    if (last_a) state <= RUN_B;
                end
                RUN_B: if (acc) begin
                    cnt_b <= cnt_b + 1'b1;
                    if (last_b) state <= IDLE;
                end
                default: if (acc) begin
                    steer <= !steer;
                    if (steer) begin
                        cnt_b <= cnt_b + 1'b1;
                        if (last_b) state <= IDLE;
                    end else cnt_a <= cnt_a + 1'b1;
                end
            endcase
        end
    end
`ifdef DP_SPLIT_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_cycles <= '0;
        else if (((a_valid && !a_ready) || (b_valid && !b_ready)) && stall_cycles != '1)
            stall_cycles <= stall_cycles + 1'b1;
    end
`endif
endmodule

// File: tb/tb_dp_stream_splitter.sv
// tb_dp_stream_splitter: directed checks of job layouts, backpressure, zero length and reset.
module tb_dp_stream_splitter;
    localparam int W = 32;
    localparam int L = 6;
    logic clk = 0, rst = 0;
    logic [W-1:0] in_data = '0;
    logic in_valid = 0, in_ready;
    logic [L-1:0] len;
    logic [W-1:0] a_data, b_data;
    logic a_valid, b_valid, busy, err_zero;
    logic a_ready = 1, b_ready = 1;
`ifdef DP_SPLIT_PERF_EN
    logic [31:0] stall_cycles;
`endif
    int checks = 0, errors = 0;
    logic [W-1:0] a_q[$], b_q[$];
    bit lane_q[$];

    dp_stream_splitter #(.WIDTH(W), .LEN_W(L)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .len(len), .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready), .busy(busy), .err_zero(err_zero)
`ifdef DP_SPLIT_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (a_valid && a_ready) begin a_q.push_back(a_data); lane_q.push_back(1'b0); end
        if (b_valid && b_ready) begin b_q.push_back(b_data); lane_q.push_back(1'b1); end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] w);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            in_data = w;
            in_valid = 1;
            #1;
            if (in_ready) begin
                @(posedge clk);
                #1 in_valid = 0;
                return;
            end
        end
        in_valid = 0;
        chk("send_timeout", 1, 0);
    endtask

    task automatic clearq();
        a_q.delete(); b_q.delete(); lane_q.delete();
    endtask

    initial begin
        int dot;
        bit ok;
        logic [W-1:0] held;
        // reset state
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_len", len, 0);
        chk("rst_a_valid", a_valid, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_a_data", a_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_zero", err_zero, 0);
        @(negedge clk) rst = 1;
        @(posedge clk) #1;
        chk("in_ready_after_rst", in_ready, 1);

        // block job N=32
        clearq();
        send(32'h20);
        chk("blk_len", len, 32);
        chk("blk_busy_lag", busy, 0);
        for (int i = 0; i < 32; i++) send(i);
        chk("blk_busy_mid", busy, 1);
        for (int i = 0; i < 32; i++) send(i);
        chk("blk_busy_last", busy, 1);
        @(posedge clk) #1;
        chk("blk_busy_fall", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("blk_a_cnt", a_q.size(), 32);
        chk("blk_b_cnt", b_q.size(), 32);
        ok = lane_q.size() == 64;
        dot = 0;
        for (int i = 0; i < 64 && ok; i++) ok = lane_q[i] == (i >= 32);
        for (int i = 0; i < 32 && ok; i++) begin
            ok = a_q[i] == i && b_q[i] == i;
            dot += int'(a_q[i]) * int'(b_q[i]);
        end
        chk("blk_order", ok, 1);
        chk("blk_dot", dot, 10416);

        // interleaved job N=32: A=i+1, B=2i
        clearq();
        send(32'h60);
        chk("il_len", len, 32);
        for (int i = 0; i < 32; i++) begin
            send(i + 1);
            send(2 * i);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("il_a_cnt", a_q.size(), 32);
        chk("il_b_cnt", b_q.size(), 32);
        ok = lane_q.size() == 64;
        for (int i = 0; i < 64 && ok; i++) ok = lane_q[i] == i[0];
        dot = 0;
        for (int i = 0; i < 32 && ok; i++) begin
            ok = a_q[i] == i + 1 && b_q[i] == 2 * i;
            dot += int'(a_q[i]) * int'(b_q[i]);
        end
        chk("il_order", ok, 1);
        chk("il_dot", dot, 21824);
        chk("il_busy_end", busy, 0);

        // backpressure on A lane, N=4 block
        clearq();
        a_ready = 0;
        send(32'h04);
        send(32'h11);
        chk("bp_a_valid", a_valid, 1);
        chk("bp_in_ready", in_ready, 0);
        held = a_data;
        chk("bp_a_data", held, 32'h11);
        ok = 1;
        repeat (5) begin
            @(negedge clk);
            ok = ok && a_data == held && a_valid && !in_ready;
        end
        chk("bp_hold", ok, 1);
        a_ready = 1;
        for (int i = 2; i <= 4; i++) send(32'h10 + i);
        for (int i = 1; i <= 4; i++) send(32'h20 + i);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_a_cnt", a_q.size(), 4);
        chk("bp_b_cnt", b_q.size(), 4);
        ok = a_q.size() == 4;
        for (int i = 0; i < 4 && ok; i++) ok = a_q[i] == 32'h11 + i;
        chk("bp_a_order", ok, 1);

        // zero length header
        send(32'h00);
        chk("zl_err_pulse", err_zero, 1);
        chk("zl_busy", busy, 0);
        @(posedge clk) #1;
        chk("zl_err_drop", err_zero, 0);
        chk("zl_len_kept", len, 4);
        chk("zl_busy2", busy, 0);
        clearq();
        send(32'h03);
        chk("zl_next_len", len, 3);
        for (int i = 0; i < 6; i++) send(32'h30 + i);
        repeat (3) @(posedge clk);
        #1;
        chk("zl_next_a", a_q.size(), 3);
        chk("zl_next_b", b_q.size(), 3);

        // reset mid-job
        send(32'h20);
        for (int i = 0; i < 10; i++) send(32'h40 + i);
        @(negedge clk) rst = 0;
        #1;
        chk("mid_a_valid", a_valid, 0);
        chk("mid_b_valid", b_valid, 0);
        chk("mid_len", len, 0);
        chk("mid_busy", busy, 0);
        chk("mid_in_ready", in_ready, 0);
        clearq();
        @(negedge clk) rst = 1;
        send(32'h02);
        chk("mid_new_len", len, 2);
        for (int i = 0; i < 4; i++) send(32'h50 + i);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_new_a", a_q.size(), 2);
        chk("mid_new_b", b_q.size(), 2);
        ok = a_q.size() == 2 && b_q.size() == 2;
        if (ok) ok = a_q[0] == 32'h50 && a_q[1] == 32'h51 && b_q[0] == 32'h52 && b_q[1] == 32'h53;
        chk("mid_new_data", ok, 1);

`ifdef DP_SPLIT_PERF_EN
        begin
            logic [31:0] s0;
            b_ready = 0;
            send(32'h01);
            send(32'h7);
            send(32'h8);
            s0 = stall_cycles;
            chk("perf_b_valid", b_valid, 1);
            repeat (7) @(posedge clk);
            #1 b_ready = 1;
            repeat (3) @(posedge clk);
            #1;
            chk("perf_stall", stall_cycles - s0, 7);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
